// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and default width for the bit-serial
//               adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Default operand/sum width
  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Combinational 1-bit full adder cell (A + B + C).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S,
  output logic Cout
);

  // Sum and carry of three single-bit inputs
  always_comb begin
    S    = A ^ B ^ C;
    Cout = (A & B) | (C & (A ^ B));
  end

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder. Time-shares one full_adder cell to compute
//               {cout,sum} = a + b + cin, LSB first, one bit per clock, with a
//               start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;   // upper result bits gathered so far
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Single shared full adder processes the current LSB pair plus carry
  full_adder u_fa (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .C    (r_carry),
    .S    (w_s),
    .Cout (w_cout)
  );

  // Handshake qualifiers and the result word after inserting this bit
  always_comb begin
    w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_last     = (r_cnt == CNT_LAST);
    w_res_next = {w_s, r_res_sr};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, serial shifting and result commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_res_sr <= w_res_next[WIDTH-1:1];
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 directed
//               cases and WIDTH=4 exhaustive sweep) with result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  typedef struct {
    logic [8:0] res;
    int         t;
  } exp8_t;

  typedef struct {
    logic [4:0] res;
    int         t;
  } exp4_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done4_cnt = 0;
  logic [8:0] last8 = '0;
  logic [8:0] held8 = '0;
  exp8_t      q8[$];
  exp4_t      q4[$];

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .start (start8), .a (a8), .b (b8), .cin (cin8),
    .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .start (start4), .a (a4), .b (b4), .cin (cin4),
    .busy (busy4), .done (done4), .sum (sum4), .cout (cout4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard for the 8-bit instance: every done must match the oldest push
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("done8_expected", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        exp8_t e;
        e = q8.pop_front();
        chk("result8", {cout8, sum8}, e.res);
        chk("latency8", cyc, e.t + 8);
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      done4_cnt++;
      if (q4.size() == 0) begin
        chk("done4_expected", 64'd0, 64'd1);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        chk("result4", {cout4, sum4}, e.res);
        chk("latency4", cyc, e.t + 4);
      end
    end
  end

  // One 8-bit operation launched from the current negedge; returns at the done cycle
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input bit hold);
    logic [8:0] e;
    a8     = av;
    b8     = bv;
    cin8   = cv;
    start8 = 1'b1;
    e = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    tick();
    q8.push_back('{res: e, t: cyc});
    held8 = last8;
    last8 = e;
    if (!hold) start8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("busy8_shift", busy8, 1);
      chk("done8_shift", done8, 0);
      chk("sum8_held", {cout8, sum8}, held8);
      if (hold) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
      end
      tick();
    end
    chk("busy8_done", busy8, 0);
    chk("done8_pulse", done8, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: everything low/zero
    for (int i = 0; i < 5; i++) begin
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 0);
      tick();
    end

    // Carry ripples through every bit
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    chk("done8_one_cycle", done8, 0);

    // Two operations, the second accepted in DONE
    run_op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op8(8'h3C, 8'h12, 1'b0, 1'b0);
    tick();

    // start held high, operands scrambled during SHIFT, back-to-back accepts
    for (int k = 0; k < 4; k++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    start8 = 1'b0;
    tick();
    chk("idle_after_burst", busy8, 0);

    // Give sum a nonzero value, then abort an operation with reset at cnt=4
    run_op8(8'h3C, 8'h12, 1'b0, 1'b0);
    tick();
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("busy_before_abort", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 0);
    last8 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk("no_done_after_abort", done8, 0);
      tick();
    end
    run_op8(8'h12, 8'h34, 1'b1, 1'b0);
    tick();

    // Exhaustive 4-bit sweep, start held high, one accept every 5 cycles
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] e4;
          a4 = x[3:0];
          b4 = y[3:0];
          cin4 = c[0];
          start4 = 1'b1;
          e4 = 5'(x) + 5'(y) + 5'(c);
          tick();
          q4.push_back('{res: e4, t: cyc});
          a4 = 4'($urandom);
          b4 = 4'($urandom);
          for (int j = 0; j < 4; j++) tick();
        end
      end
    end
    start4 = 1'b0;
    for (int j = 0; j < 6; j++) tick();

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    chk("done4_count", done4_cnt, 512);
    chk("busy4_idle", busy4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
